keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 179 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and a
// valid/ready key-code output. Rows are driven one at a time (active-low),
// columns are sampled through a two-flop synchronizer, and a single key is
// tracked from first detection through confirmed release.
module keypad_scanner #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SCAN_US     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held
);

  // Cycle counts derived from the clock frequency. ROW_CYCLES must be at
  // least 4 so that a freshly driven row has propagated through the
  // synchronizer before its columns are evaluated.
  localparam int unsigned DEBOUNCE_COUNT = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int unsigned ROW_CYCLES     = (CLK_FREQ / 1_000_000) * SCAN_US;

  localparam logic [31:0] DEB_LAST = DEBOUNCE_COUNT - 1;
  localparam logic [31:0] ROW_LAST = ROW_CYCLES - 1;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    REPORT,
    RELEASE
  } state_t;

  // Synchronizer stages.
  logic [3:0] col_meta;
  logic [3:0] col_sync;

  // FSM state and its next-state counterparts.
  state_t      state_q,    state_d;
  logic [1:0]  row_idx_q,  row_idx_d;
  logic [1:0]  col_idx_q,  col_idx_d;
  logic [31:0] cnt_q,      cnt_d;

  // Next values of the registered outputs.
  logic [3:0]  row_n_d;
  logic        key_valid_d;
  logic [3:0]  key_code_d;
  logic        key_held_d;

  // Index of the lowest-numbered column that reads low; only meaningful when
  // at least one column is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous column lines.
  // NOTE: the synchronizer resets to the idle (all-high) pattern rather than
  // zero, so the FSM never sees a phantom key press straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Next-state and next-output logic for the scan/debounce/report/release FSM.
  // NOTE: every signal gets a default hold value before the case statement;
  // a branch that forgets to assign one would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid;
    key_code_d  = key_code;
    key_held_d  = key_held;

    unique case (state_q)
      // Dwell on the current row; look at the columns on the last dwell cycle.
      SCAN: begin
        if (cnt_q == ROW_LAST) begin
          cnt_d = '0;
          if (col_sync == 4'hF) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            col_idx_d = lowest_low(col_sync);
            state_d   = DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Require the latched column to stay low for the full debounce time.
      DEBOUNCE: begin
        if (col_sync[col_idx_q]) begin
          cnt_d     = '0;
          row_idx_d = row_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d       = '0;
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = REPORT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Hold the code until the consumer takes it; release is ignored here.
      REPORT: begin
        if (key_valid && key_ready) begin
          cnt_d       = '0;
          key_valid_d = 1'b0;
          state_d     = RELEASE;
        end
      end

      // Require all columns high for the full debounce time before rescanning.
      RELEASE: begin
        if (col_sync != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d      = '0;
          row_idx_d  = row_idx_q + 2'd1;
          key_held_d = 1'b0;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase

    // Drive the row selected for the coming cycle; exactly one line low.
    row_n_d = ~(4'b0001 << row_idx_d);
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      cnt_q     <= '0;
      row_n     <= 4'hF;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      cnt_q     <= cnt_d;
      row_n     <= row_n_d;
      key_valid <= key_valid_d;
      key_code  <= key_code_d;
      key_held  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a
// behavioural 4x4 keypad model and a key-code scoreboard.
module tb_keypad_scanner;

  localparam int unsigned CLK_FREQ    = 1_000_000;
  localparam int unsigned DEBOUNCE_MS = 1;
  localparam int unsigned SCAN_US     = 4;
  localparam int ROWC = 4;     // row dwell cycles
  localparam int DEB  = 1000;  // debounce cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready = 1'b0;
  logic       key_held;

  logic [15:0] pressed = '0;   // pressed[row*4+col]
  int checks = 0;
  int fails = 0;
  int accept_count = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(
    .CLK_FREQ   (CLK_FREQ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .SCAN_US    (SCAN_US)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_n[r] === 1'b0) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  // Count accepted handshakes.
  always @(posedge clk) begin
    if (rst_n && key_valid === 1'b1 && key_ready === 1'b1) accept_count <= accept_count + 1;
  end

  // Bounded waits, all sampling on the falling edge.
  task automatic wait_row(input logic [3:0] pat, input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (row_n === pat) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (key_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_held_low(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (key_held === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (row_n !== 4'hF) begin fails++; $display("FAIL reset_row_n: observed %b, expected 1111", row_n); end
    checks++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: observed %b, expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_key_code: observed %h, expected 0", key_code); end
    checks++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_key_held: observed %b, expected 0", key_held); end
    repeat (3) @(negedge clk);
    checks++; if (row_n !== 4'hF) begin fails++; $display("FAIL reset_hold_row_n: observed %b, expected 1111", row_n); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (row_n !== 4'b1110) begin fails++; $display("FAIL reset_first_edge_row_n: observed %b, expected 1110", row_n); end
  endtask

  // Called #1 after the first edge out of reset; row r is held from edge 4r.
  task automatic test_scan_idle();
    logic [3:0] exp_row;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      exp_row = ~(4'b0001 << ((k / ROWC) % 4));
      checks++;
      if (row_n !== exp_row || key_valid !== 1'b0) begin
        fails++;
        $display("FAIL scan_idle_cycle_%0d: observed row_n=%b valid=%b, expected row_n=%b valid=0", k, row_n, key_valid, exp_row);
      end
    end
  endtask

  task automatic test_key_report();
    int cyc, acc0;
    bit ok, extra;
    logic [3:0] exp_code;
    key_ready = 1'b1;
    wait_row(4'b1101, 100, cyc, ok);
    pressed[9] = 1'b1;
    exp_q.push_back(4'd9);
    acc0 = accept_count;
    wait_row(4'b1011, 100, cyc, ok);
    checks++; if (!ok) begin fails++; $display("FAIL report_reach_row2: observed timeout, expected row_n 1011"); end
    wait_valid(3000, cyc, ok);
    checks++; if (!ok || cyc != ROWC + DEB) begin fails++; $display("FAIL report_latency: observed %0d cycles (ok=%0d), expected %0d", cyc, ok, ROWC + DEB); end
    if (ok) begin
      exp_code = exp_q.pop_front();
      checks++; if (key_code !== exp_code) begin fails++; $display("FAIL report_code: observed %h, expected %h", key_code, exp_code); end
      checks++; if (key_held !== 1'b1) begin fails++; $display("FAIL report_held: observed %b, expected 1", key_held); end
    end
    @(negedge clk);
    checks++; if (key_valid !== 1'b0 || key_held !== 1'b1) begin fails++; $display("FAIL report_single_pulse: observed valid=%b held=%b, expected valid=0 held=1", key_valid, key_held); end
    extra = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (key_valid !== 1'b0 || key_held !== 1'b1) extra = 1'b1;
    end
    checks++; if (extra) begin fails++; $display("FAIL report_no_repeat_while_held: observed repeat or held drop, expected none"); end
    checks++; if (accept_count != acc0 + 1) begin fails++; $display("FAIL report_accept_count: observed %0d, expected %0d", accept_count - acc0, 1); end
    pressed[9] = 1'b0;
    wait_held_low(3000, cyc, ok);
    checks++; if (!ok || cyc != DEB + 2) begin fails++; $display("FAIL release_latency: observed %0d cycles (ok=%0d), expected %0d", cyc, ok, DEB + 2); end
    checks++; if (row_n !== 4'b0111) begin fails++; $display("FAIL release_next_row: observed %b, expected 0111", row_n); end
  endtask

  task automatic test_press_reject();
    int cyc, acc0;
    bit ok, bad;
    key_ready = 1'b1;
    acc0 = accept_count;
    wait_row(4'b1101, 100, cyc, ok);
    pressed[7] = 1'b1;
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (key_valid !== 1'b0 || key_held !== 1'b0 || row_n !== 4'b1101) bad = 1'b1;
    end
    checks++; if (bad) begin fails++; $display("FAIL reject_during_press: observed valid/held/row change, expected idle on row 1"); end
    pressed[7] = 1'b0;
    ok = 1'b0;
    cyc = 0;
    while (cyc < 10 && !ok) begin
      @(negedge clk);
      cyc++;
      if (row_n !== 4'b1101) ok = 1'b1;
    end
    checks++; if (!ok || row_n !== 4'b1011 || cyc > 4) begin fails++; $display("FAIL reject_resume_row: observed %b after %0d cycles, expected 1011 within 4", row_n, cyc); end
    repeat (20) @(negedge clk);
    checks++; if (accept_count != acc0) begin fails++; $display("FAIL reject_no_report: observed %0d reports, expected 0", accept_count - acc0); end
  endtask

  task automatic test_no_ready_hold();
    int cyc, acc0;
    bit ok, bad;
    logic [3:0] exp_code;
    key_ready = 1'b0;
    acc0 = accept_count;
    wait_row(4'b1101, 100, cyc, ok);
    pressed[12] = 1'b1;
    pressed[14] = 1'b1;
    exp_q.push_back(4'd12);
    wait_row(4'b0111, 100, cyc, ok);
    wait_valid(3000, cyc, ok);
    checks++; if (!ok || cyc != ROWC + DEB) begin fails++; $display("FAIL hold_latency: observed %0d cycles (ok=%0d), expected %0d", cyc, ok, ROWC + DEB); end
    if (ok) begin
      exp_code = exp_q.pop_front();
      checks++; if (key_code !== exp_code) begin fails++; $display("FAIL hold_code: observed %h, expected %h", key_code, exp_code); end
    end
    bad = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i == 2500) begin pressed[12] = 1'b0; pressed[14] = 1'b0; end
      if (key_valid !== 1'b1 || key_code !== 4'd12 || key_held !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin fails++; $display("FAIL hold_stable: observed valid=%b code=%h, expected valid=1 code=c throughout", key_valid, key_code); end
    key_ready = 1'b1;
    @(negedge clk);
    checks++; if (key_valid !== 1'b0 || accept_count != acc0 + 1) begin fails++; $display("FAIL hold_accept: observed valid=%b accepts=%0d, expected valid=0 accepts=1", key_valid, accept_count - acc0); end
    wait_held_low(3000, cyc, ok);
    checks++; if (!ok || cyc != DEB) begin fails++; $display("FAIL hold_release_latency: observed %0d cycles (ok=%0d), expected %0d", cyc + 1, ok, DEB + 1); end
  endtask

  task automatic test_release_bounce();
    int cyc;
    bit ok, bad;
    logic [3:0] exp_code;
    key_ready = 1'b1;
    wait_row(4'b1110, 100, cyc, ok);
    pressed[6] = 1'b1;
    exp_q.push_back(4'd6);
    wait_valid(3000, cyc, ok);
    checks++; if (!ok) begin fails++; $display("FAIL bounce_report: observed timeout, expected key_valid"); end
    if (ok) begin
      exp_code = exp_q.pop_front();
      checks++; if (key_code !== exp_code) begin fails++; $display("FAIL bounce_code: observed %h, expected %h", key_code, exp_code); end
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pressed[6] = (i % 2 == 1);
      repeat (200) begin
        @(negedge clk);
        if (key_held !== 1'b1) bad = 1'b1;
      end
    end
    checks++; if (bad) begin fails++; $display("FAIL bounce_held: observed key_held drop during bounce, expected held"); end
    pressed[6] = 1'b0;
    wait_held_low(3000, cyc, ok);
    checks++; if (!ok || cyc != DEB + 2) begin fails++; $display("FAIL bounce_release_latency: observed %0d cycles (ok=%0d), expected %0d", cyc, ok, DEB + 2); end
    checks++; if (row_n !== 4'b1011) begin fails++; $display("FAIL bounce_next_row: observed %b, expected 1011", row_n); end
  endtask

  task automatic test_reset_in_report();
    int cyc, acc0;
    bit ok;
    logic [3:0] exp_code;
    key_ready = 1'b0;
    acc0 = accept_count;
    wait_row(4'b1101, 100, cyc, ok);
    pressed[0] = 1'b1;
    exp_q.push_back(4'd0);
    wait_valid(3000, cyc, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rst_report_reach: observed timeout, expected key_valid"); end
    exp_code = exp_q.pop_front();  // pending key is lost by the reset below
    #2 rst_n = 1'b0;
    #1;
    checks++; if (key_valid !== 1'b0 || key_held !== 1'b0 || row_n !== 4'hF) begin fails++; $display("FAIL rst_in_report: observed valid=%b held=%b row_n=%b, expected 0 0 1111", key_valid, key_held, row_n); end
    checks++; if (key_code !== 4'h0) begin fails++; $display("FAIL rst_in_report_code: observed %h, expected 0 (lost %h)", key_code, exp_code); end
    pressed[0] = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (row_n !== 4'b1110) begin fails++; $display("FAIL rst_restart_row0: observed %b, expected 1110", row_n); end
    repeat (1100) @(negedge clk);
    checks++; if (accept_count != acc0 || key_valid !== 1'b0) begin fails++; $display("FAIL rst_key_lost: observed accepts=%0d valid=%b, expected 0 0", accept_count - acc0, key_valid); end
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_key_report();
    test_press_reject();
    test_no_ready_hold();
    test_release_bounce();
    test_reset_in_report();
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_empty: observed %0d pending, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
